// File: rtl/fpnew_shared_issue_arbiter.sv
// fpnew_shared_issue_arbiter: shares one FPU issue port among NumReq
// requesters (round-robin, grant lock, ID tag, credits, result routing).
// Ports: clk_i, rst_i (sync, active-high), flush_i;
//   req_valid_i/req_ready_o/req_data_i   core-side issue, one per requester
//   fpu_valid_o/fpu_ready_i/fpu_data_o/fpu_id_o   issue toward the FPU
//   rsp_valid_i/rsp_ready_o/rsp_id_i/rsp_data_i   result from the FPU
//   rsp_valid_o/rsp_ready_i/rsp_data_o   result toward requesters
//   id_err_o (sticky bad ID / credit underflow), busy_o, stall_cnt_o.
// Optional feature macro: FPNEW_SHARED_ARB_PERF_EN enables the
// per-requester stall counters; otherwise stall_cnt_o is tied to zero.
module fpnew_shared_issue_arbiter #(
   parameter int unsigned NumReq         = 4,
   parameter int unsigned PayloadWidth   = 128,
   parameter int unsigned RspWidth       = 38,
   parameter int unsigned MaxOutstanding = 4,
   localparam int unsigned IdWidth       = $clog2(NumReq)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic [NumReq-1:0]              req_valid_i,
   output logic [NumReq-1:0]              req_ready_o,
   input  logic [NumReq*PayloadWidth-1:0] req_data_i,
   output logic                           fpu_valid_o,
   input  logic                           fpu_ready_i,
   output logic [PayloadWidth-1:0]        fpu_data_o,
   output logic [IdWidth-1:0]             fpu_id_o,
   input  logic                           rsp_valid_i,
   output logic                           rsp_ready_o,
   input  logic [IdWidth-1:0]             rsp_id_i,
   input  logic [RspWidth-1:0]            rsp_data_i,
   output logic [NumReq-1:0]              rsp_valid_o,
   input  logic [NumReq-1:0]              rsp_ready_i,
   output logic [RspWidth-1:0]            rsp_data_o,
   output logic                           id_err_o,
   output logic                           busy_o,
   output logic [NumReq*16-1:0]           stall_cnt_o
);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e             state_q;
   logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdWidth-1:0] lock_id_q;
   logic [IdWidth-1:0] grant, sel;
   logic [3:0]         cnt_q [NumReq];
   logic [3:0]         cnt_d [NumReq];
   logic [NumReq-1:0]  elig;
   logic               any_elig;
   logic               kill;
   logic               issue_hs;
   logic               rsp_id_ok;
   logic               rsp_hs;
   logic               underflow;
   logic               id_err_q;

   // Reset and flush both suppress every handshake in the current cycle.
   assign kill = rst_i | flush_i;

   // Round-robin: first eligible requester at or after rr_ptr_q.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      grant    = '0;
      any_elig = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++)
         elig[i] = req_valid_i[i] & (cnt_q[i] < 4'(MaxOutstanding));
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx = (32'(rr_ptr_q) + i) % NumReq;
         if (!any_elig && elig[idx]) begin
            any_elig = 1'b1;
            grant    = IdWidth'(idx);
         end
      end
   end

   // A locked grant ignores credit and other requesters until it handshakes.
   always_comb begin
      if (state_q == LOCKED) begin
         sel         = lock_id_q;
         fpu_valid_o = ~kill & req_valid_i[lock_id_q];
      end else begin
         sel         = grant;
         fpu_valid_o = ~kill & any_elig;
      end
   end

   assign fpu_data_o = req_data_i[32'(sel)*PayloadWidth +: PayloadWidth];
   assign fpu_id_o   = sel;
   assign issue_hs   = fpu_valid_o & fpu_ready_i;

   always_comb begin
      req_ready_o      = '0;
      req_ready_o[sel] = issue_hs;
   end

   // Response routing; unknown IDs are accepted and dropped.
   assign rsp_id_ok  = 32'(rsp_id_i) < NumReq;
   assign rsp_data_o = rsp_data_i;

   always_comb begin
      rsp_valid_o = '0;
      rsp_ready_o = 1'b1;
      if (!kill && rsp_id_ok) begin
         rsp_valid_o[rsp_id_i] = rsp_valid_i;
         rsp_ready_o           = rsp_ready_i[rsp_id_i];
      end
   end

   assign rsp_hs    = rsp_valid_i & rsp_ready_o & ~kill & rsp_id_ok;
   assign underflow = rsp_hs & (cnt_q[rsp_id_i] == 4'd0);

   // Credit counters: issue and return to the same requester cancel out.
   always_comb begin
      logic inc, dec;
      inc = 1'b0;
      dec = 1'b0;
      for (int unsigned r = 0; r < NumReq; r++) begin
         inc      = issue_hs & (32'(sel) == r);
         dec      = rsp_hs & (32'(rsp_id_i) == r);
         cnt_d[r] = cnt_q[r];
         if (inc && !dec && cnt_q[r] != 4'hF)
            cnt_d[r] = cnt_q[r] + 4'd1;
         else if (dec && !inc && cnt_q[r] != 4'd0)
            cnt_d[r] = cnt_q[r] - 4'd1;
      end
      rr_ptr_d = issue_hs ? IdWidth'((32'(sel) + 1) % NumReq) : rr_ptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         lock_id_q <= '0;
         id_err_q  <= 1'b0;
         for (int unsigned r = 0; r < NumReq; r++)
            cnt_q[r] <= '0;
      end else begin
         if ((rsp_valid_i && !rsp_id_ok) || underflow)
            id_err_q <= 1'b1;
         if (flush_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            for (int unsigned r = 0; r < NumReq; r++)
               cnt_q[r] <= '0;
         end else begin
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= sel;
            state_q   <= (fpu_valid_o && !fpu_ready_i) ? LOCKED : IDLE;
         end
      end
   end

   assign id_err_o = id_err_q;

   always_comb begin
      busy_o = fpu_valid_o;
      for (int unsigned r = 0; r < NumReq; r++)
         busy_o = busy_o | (cnt_q[r] != 4'd0);
   end

`ifdef FPNEW_SHARED_ARB_PERF_EN
   logic [15:0] stall_q [NumReq];

   // Saturating; survives flush, cleared by reset only.
   always_ff @(posedge clk_i) begin
      for (int unsigned r = 0; r < NumReq; r++) begin
         if (rst_i)
            stall_q[r] <= '0;
         else if (req_valid_i[r] && !req_ready_o[r] && stall_q[r] != 16'hFFFF)
            stall_q[r] <= stall_q[r] + 16'd1;
      end
   end

   always_comb begin
      stall_cnt_o = '0;
      for (int unsigned r = 0; r < NumReq; r++)
         stall_cnt_o[r*16 +: 16] = stall_q[r];
   end
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpnew_shared_issue_arbiter.sv
// tb_fpnew_shared_issue_arbiter: directed self-checking bench.
// Main instance NumReq=4; a NumReq=3 instance exercises out-of-range IDs.
module tb_fpnew_shared_issue_arbiter;

   logic         clk;
   logic         rst;
   logic         flush;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [511:0] req_data;
   logic         fpu_valid;
   logic         fpu_ready;
   logic [127:0] fpu_data;
   logic [1:0]   fpu_id;
   logic         rsp_valid_in;
   logic         rsp_ready_out;
   logic [1:0]   rsp_id;
   logic [37:0]  rsp_data_in;
   logic [3:0]   rsp_valid_out;
   logic [3:0]   rsp_ready_in;
   logic [37:0]  rsp_data_out;
   logic         id_err;
   logic         busy;
   logic [63:0]  stall;

   logic         b_flush;
   logic [2:0]   b_req_valid;
   logic [2:0]   b_req_ready;
   logic [23:0]  b_req_data;
   logic         b_fpu_valid;
   logic [7:0]   b_fpu_data;
   logic [1:0]   b_fpu_id;
   logic         b_rsp_valid_in;
   logic         b_rsp_ready_out;
   logic [1:0]   b_rsp_id;
   logic [2:0]   b_rsp_valid_out;
   logic [2:0]   b_rsp_ready_in;
   logic [7:0]   b_rsp_data_out;
   logic         b_id_err;
   logic         b_busy;
   logic [47:0]  b_stall;

   int assertions = 0;
   int failures   = 0;

   fpnew_shared_issue_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_data_i  (req_data),
      .fpu_valid_o (fpu_valid),
      .fpu_ready_i (fpu_ready),
      .fpu_data_o  (fpu_data),
      .fpu_id_o    (fpu_id),
      .rsp_valid_i (rsp_valid_in),
      .rsp_ready_o (rsp_ready_out),
      .rsp_id_i    (rsp_id),
      .rsp_data_i  (rsp_data_in),
      .rsp_valid_o (rsp_valid_out),
      .rsp_ready_i (rsp_ready_in),
      .rsp_data_o  (rsp_data_out),
      .id_err_o    (id_err),
      .busy_o      (busy),
      .stall_cnt_o (stall)
   );

   fpnew_shared_issue_arbiter #(
      .NumReq       (3),
      .PayloadWidth (8),
      .RspWidth     (8)
   ) dut_b (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (b_flush),
      .req_valid_i (b_req_valid),
      .req_ready_o (b_req_ready),
      .req_data_i  (b_req_data),
      .fpu_valid_o (b_fpu_valid),
      .fpu_ready_i (1'b1),
      .fpu_data_o  (b_fpu_data),
      .fpu_id_o    (b_fpu_id),
      .rsp_valid_i (b_rsp_valid_in),
      .rsp_ready_o (b_rsp_ready_out),
      .rsp_id_i    (b_rsp_id),
      .rsp_data_i  (8'h5A),
      .rsp_valid_o (b_rsp_valid_out),
      .rsp_ready_i (b_rsp_ready_in),
      .rsp_data_o  (b_rsp_data_out),
      .id_err_o    (b_id_err),
      .busy_o      (b_busy),
      .stall_cnt_o (b_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush          = 1'b0;
      req_valid      = '0;
      fpu_ready      = 1'b0;
      rsp_valid_in   = 1'b0;
      rsp_id         = '0;
      rsp_ready_in   = '0;
      rsp_data_in    = 38'h15_0000_ABCD;
      b_flush        = 1'b0;
      b_req_valid    = '0;
      b_req_data     = 24'h332211;
      b_rsp_valid_in = 1'b0;
      b_rsp_id       = '0;
      b_rsp_ready_in = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      assertions++;
      if (fpu_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_fpu_valid: got %b, required 0", fpu_valid);
      end
      assertions++;
      if (req_ready !== 4'b0) begin
         failures++;
         $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
      end
      assertions++;
      if (rsp_valid_out !== 4'b0) begin
         failures++;
         $display("FAIL reset_rsp_valid: got %b, required 0000", rsp_valid_out);
      end
      assertions++;
      if (busy !== 1'b0 || id_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: got busy=%b id_err=%b, required 0 0", busy, id_err);
      end
      assertions++;
      if (stall !== 64'b0) begin
         failures++;
         $display("FAIL reset_stall: got %h, required 0", stall);
      end
   endtask

   task automatic test_fairness();
      logic [127:0] exp_data;
      int           e;
      do_reset();
      req_valid    = 4'b1111;
      fpu_ready    = 1'b1;
      rsp_ready_in = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         e            = k % 4;
         exp_data     = {4{32'hA000_0000 + 32'(e)}};
         rsp_valid_in = (k > 0);
         rsp_id       = 2'((k + 3) % 4);
         #1;
         assertions++;
         if (fpu_valid !== 1'b1 || fpu_id !== 2'(e)) begin
            failures++;
            $display("FAIL fair_id[%0d]: got v=%b id=%0d, required v=1 id=%0d",
                     k, fpu_valid, fpu_id, e);
         end
         assertions++;
         if (req_ready !== 4'(1 << e) || fpu_data !== exp_data) begin
            failures++;
            $display("FAIL fair_ready_data[%0d]: got rdy=%b data=%h, required rdy=%b data=%h",
                     k, req_ready, fpu_data, 4'(1 << e), exp_data);
         end
         if (k > 0) begin
            assertions++;
            if (rsp_valid_out !== 4'(1 << ((k + 3) % 4))) begin
               failures++;
               $display("FAIL fair_rsp_route[%0d]: got %b, required %b",
                        k, rsp_valid_out, 4'(1 << ((k + 3) % 4)));
            end
         end
         tick();
      end
      req_valid    = '0;
      rsp_valid_in = 1'b1;
      rsp_id       = 2'd3;
      tick();
      rsp_valid_in = 1'b0;
      #1;
      assertions++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL fair_drained: got busy=%b, required 0", busy);
      end
   endtask

   task automatic test_lock();
      do_reset();
      req_valid = 4'b0100;
      fpu_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) req_valid = 4'b0101;
         #1;
         assertions++;
         if (fpu_valid !== 1'b1 || fpu_id !== 2'd2 || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL lock_hold[%0d]: got v=%b id=%0d rdy=%b, required v=1 id=2 rdy=0000",
                     c, fpu_valid, fpu_id, req_ready);
         end
         tick();
      end
      fpu_ready = 1'b1;
      #1;
      assertions++;
      if (fpu_id !== 2'd2 || req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL lock_release: got id=%0d rdy=%b, required id=2 rdy=0100",
                  fpu_id, req_ready);
      end
      tick();
      req_valid = 4'b0001;
      #1;
      assertions++;
      if (fpu_id !== 2'd0 || req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL lock_next: got id=%0d rdy=%b, required id=0 rdy=0001",
                  fpu_id, req_ready);
      end
      tick();
      // lock on requester 1, then reset while the FPU becomes ready
      req_valid = 4'b0010;
      fpu_ready = 1'b0;
      tick();
      rst       = 1'b1;
      fpu_ready = 1'b1;
      #1;
      assertions++;
      if (fpu_valid !== 1'b0 || req_ready !== 4'b0) begin
         failures++;
         $display("FAIL lock_reset: got v=%b rdy=%b, required v=0 rdy=0000",
                  fpu_valid, req_ready);
      end
      tick();
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_credit();
      do_reset();
      req_valid = 4'b0010;
      fpu_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         assertions++;
         if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL credit_issue[%0d]: got %b, required 0010", c, req_ready);
         end
         tick();
      end
      #1;
      assertions++;
      if (req_ready !== 4'b0 || fpu_valid !== 1'b0) begin
         failures++;
         $display("FAIL credit_block: got rdy=%b v=%b, required rdy=0000 v=0",
                  req_ready, fpu_valid);
      end
      rsp_valid_in = 1'b1;
      rsp_id       = 2'd1;
      rsp_ready_in = 4'b1111;
      #1;
      assertions++;
      if (rsp_valid_out !== 4'b0010 || rsp_ready_out !== 1'b1 || req_ready !== 4'b0) begin
         failures++;
         $display("FAIL credit_rsp: got rv=%b rr=%b rdy=%b, required rv=0010 rr=1 rdy=0000",
                  rsp_valid_out, rsp_ready_out, req_ready);
      end
      assertions++;
      if (rsp_data_out !== rsp_data_in) begin
         failures++;
         $display("FAIL credit_rsp_data: got %h, required %h", rsp_data_out, rsp_data_in);
      end
      tick();
      rsp_valid_in = 1'b0;
      #1;
      assertions++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL credit_fifth: got %b, required 0010", req_ready);
      end
      tick();
      req_valid = '0;
      #1;
      assertions++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL credit_busy: got %b, required 1", busy);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      req_valid    = 4'b1000;
      fpu_ready    = 1'b1;
      rsp_ready_in = 4'b1111;
      tick();
      tick();
      rsp_valid_in = 1'b1;
      rsp_id       = 2'd3;
      #1;
      assertions++;
      if (req_ready !== 4'b1000 || rsp_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL simul_hs: got rdy=%b rr=%b, required rdy=1000 rr=1",
                  req_ready, rsp_ready_out);
      end
      tick();
      req_valid = '0;
      tick();
      rsp_valid_in = 1'b0;
      #1;
      assertions++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL simul_one_left: got busy=%b, required 1", busy);
      end
      rsp_valid_in = 1'b1;
      tick();
      rsp_valid_in = 1'b0;
      #1;
      assertions++;
      if (busy !== 1'b0 || id_err !== 1'b0) begin
         failures++;
         $display("FAIL simul_drained: got busy=%b id_err=%b, required 0 0",
                  busy, id_err);
      end
   endtask

   task automatic test_bad_id();
      do_reset();
      b_rsp_valid_in = 1'b1;
      b_rsp_id       = 2'd3;
      b_rsp_ready_in = 3'b000;
      #1;
      assertions++;
      if (b_rsp_ready_out !== 1'b1 || b_rsp_valid_out !== 3'b0) begin
         failures++;
         $display("FAIL badid_drop: got rr=%b rv=%b, required rr=1 rv=000",
                  b_rsp_ready_out, b_rsp_valid_out);
      end
      tick();
      b_rsp_valid_in = 1'b0;
      #1;
      assertions++;
      if (b_id_err !== 1'b1) begin
         failures++;
         $display("FAIL badid_err: got %b, required 1", b_id_err);
      end
      b_flush = 1'b1;
      tick();
      b_flush = 1'b0;
      tick();
      assertions++;
      if (b_id_err !== 1'b1) begin
         failures++;
         $display("FAIL badid_flush_keep: got %b, required 1", b_id_err);
      end
      // response at zero credit on the main instance
      rsp_valid_in = 1'b1;
      rsp_id       = 2'd0;
      rsp_ready_in = 4'b1111;
      #1;
      assertions++;
      if (rsp_valid_out !== 4'b0001 || id_err !== 1'b0) begin
         failures++;
         $display("FAIL underflow_pre: got rv=%b err=%b, required rv=0001 err=0",
                  rsp_valid_out, id_err);
      end
      tick();
      rsp_valid_in = 1'b0;
      #1;
      assertions++;
      if (id_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL underflow: got err=%b busy=%b, required err=1 busy=0",
                  id_err, busy);
      end
   endtask

   task automatic test_flush_perf();
      logic [15:0] exp0, exp1, exp2;
`ifdef FPNEW_SHARED_ARB_PERF_EN
      exp0 = 16'd10;
      exp1 = 16'd1;
      exp2 = 16'd2;
`else
      exp0 = 16'd0;
      exp1 = 16'd0;
      exp2 = 16'd0;
`endif
      do_reset();
      req_valid = 4'b0110;
      fpu_ready = 1'b1;
      tick();
      tick();
      tick();
      req_valid = 4'b0001;
      fpu_ready = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      #1;
      assertions++;
      if (busy !== 1'b1 || fpu_id !== 2'd0) begin
         failures++;
         $display("FAIL flush_pre: got busy=%b id=%0d, required busy=1 id=0", busy, fpu_id);
      end
      req_valid    = '0;
      flush        = 1'b1;
      rsp_valid_in = 1'b1;
      rsp_id       = 2'd1;
      rsp_ready_in = 4'b0000;
      #1;
      assertions++;
      if (rsp_valid_out !== 4'b0 || rsp_ready_out !== 1'b1 || fpu_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_cycle: got rv=%b rr=%b v=%b, required rv=0000 rr=1 v=0",
                  rsp_valid_out, rsp_ready_out, fpu_valid);
      end
      tick();
      flush        = 1'b0;
      rsp_valid_in = 1'b0;
      #1;
      assertions++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_busy: got %b, required 0", busy);
      end
      assertions++;
      if (stall[15:0] !== exp0) begin
         failures++;
         $display("FAIL perf_stall0: got %0d, required %0d", stall[15:0], exp0);
      end
      assertions++;
      if (stall[31:16] !== exp1 || stall[47:32] !== exp2) begin
         failures++;
         $display("FAIL perf_stall12: got %0d %0d, required %0d %0d",
                  stall[31:16], stall[47:32], exp1, exp2);
      end
      req_valid = 4'b0110;
      #1;
      assertions++;
      if (fpu_valid !== 1'b1 || fpu_id !== 2'd1) begin
         failures++;
         $display("FAIL flush_rrptr: got v=%b id=%0d, required v=1 id=1", fpu_valid, fpu_id);
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      for (int r = 0; r < 4; r++)
         req_data[r*128 +: 128] = {4{32'hA000_0000 + 32'(r)}};
      idle_inputs();
      test_reset();
      test_fairness();
      test_lock();
      test_credit();
      test_simultaneous();
      test_bad_id();
      test_flush_perf();
      $display("End of test - %0d assertions evaluated, %0d failures",
               assertions, failures);
      $finish;
   end

endmodule
